vga_sync_decoder: RTL

- Receive-side counterpart of the VGA timing generator: samples incoming hsync/vsync on the pixel clock and recovers pixel_x/pixel_y, an active-video flag and a lock indicator.
- Sits behind the VGA output pins (loopback/self-check path) or on a capture port, and verifies that the transmitted timing matches the configured 640x480 mode.

---
 rtl/vga_sync_decoder.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/vga_sync_decoder.sv
// ---------------------------------------------------------------------------
// vga_sync_decoder
//   Receive-side VGA timing recovery. Samples hsync/vsync on the pixel clock,
//   rebuilds the raster position and reports whether the incoming stream
//   matches the configured mode (default 640x480, 800x525 total).
//
//   Ports
//     clk_div       in   pixel clock
//     reset         in   asynchronous, active-high
//     hsync, vsync  in   active-low syncs, already in the clk_div domain
//     pixel_x/y     out  recovered column / line (16 bit)
//     video_active  out  locked and inside the visible window
//     locked        out  high while in LOCKED
//     frame_start   out  1-cycle pulse at (0,0) while locked
//     sync_error    out  1-cycle pulse on a timing mismatch or watchdog expiry
//
//   Build option
//     VGA_SYNC_WIDTH_CHECK_EN : also verify the hsync low width against
//                               H_SYNC_WIDTH; a wrong width is treated as a
//                               bad horizontal edge.
// ---------------------------------------------------------------------------
module vga_sync_decoder #(
    parameter int H_TOTAL      = 800,
    parameter int H_VISIBLE    = 640,
    parameter int H_SYNC_START = 656,
    parameter int H_SYNC_WIDTH = 96,
    parameter int V_TOTAL      = 525,
    parameter int V_VISIBLE    = 480,
    parameter int V_SYNC_START = 490,
    parameter int LOCK_FRAMES  = 2
) (
    input  logic        clk_div,
    input  logic        reset,
    input  logic        hsync,
    input  logic        vsync,
    output logic [15:0] pixel_x,
    output logic [15:0] pixel_y,
    output logic        video_active,
    output logic        locked,
    output logic        frame_start,
    output logic        sync_error
);

    typedef enum logic [1:0] {SEARCH, H_ALIGN, VERIFY, LOCKED} state_t;

    localparam int CW = $clog2(LOCK_FRAMES + 1);

    // The sync pulse has to fit inside the line.
    if (H_SYNC_START + H_SYNC_WIDTH > H_TOTAL) begin : g_bad_cfg
        $error("vga_sync_decoder: hsync pulse extends past H_TOTAL");
    end

    state_t        state, state_n;
    logic          hs_d1, hs_d2, hs_d3;
    logic          vs_d1, vs_d2;      // vsync is only consumed at the d2 tap
    logic          line_vs;           // vsync level captured at the last hsync edge
    logic [CW-1:0] good_cnt, good_cnt_n;
    logic [15:0]   wd, wd_n;
    logic [15:0]   x_n, y_n;
    logic          err_n;
    logic          h_edge, h_bad, v_start, v_bad, w_bad, wd_expire;

    assign h_edge    = !hs_d2 && hs_d3;
    assign h_bad     = h_edge && (pixel_x != 16'(H_SYNC_START - 1));
    // A vsync start line is the first line whose hsync edge sees vsync low.
    assign v_start   = h_edge && !vs_d2 && line_vs;
    assign v_bad     = v_start && (pixel_y != 16'(V_SYNC_START));
    // Fires on the clock where the count would reach 2*H_TOTAL without an edge.
    assign wd_expire = (state != SEARCH) && !h_edge && (wd == 16'(2 * H_TOTAL - 1));

`ifdef VGA_SYNC_WIDTH_CHECK_EN
    logic [15:0] hw_cnt;
    logic        h_rise;

    assign h_rise = hs_d2 && !hs_d3;
    // At the rising edge hw_cnt holds the number of low samples seen at d2.
    assign w_bad  = h_rise && (hw_cnt != 16'(H_SYNC_WIDTH));

    always_ff @(posedge clk_div or posedge reset) begin
        if (reset)       hw_cnt <= 16'd0;
        else if (h_edge) hw_cnt <= 16'd1;
        else if (!hs_d2) hw_cnt <= hw_cnt + 16'd1;
    end
`else
    assign w_bad = 1'b0;
`endif

    always_comb begin
        state_n    = state;
        good_cnt_n = good_cnt;
        err_n      = 1'b0;
        x_n        = 16'd0;
        y_n        = 16'd0;
        wd_n       = 16'd0;
        if (state == SEARCH) begin
            good_cnt_n = '0;
            if (h_edge) begin
                state_n = H_ALIGN;
                x_n     = 16'(H_SYNC_START);
            end
        end else if (wd_expire) begin
            // Lost hsync entirely: drop back and start over from (0,0).
            state_n    = SEARCH;
            good_cnt_n = '0;
            err_n      = 1'b1;
        end else begin
            wd_n = h_edge ? 16'd0 : wd + 16'd1;
            if (pixel_x == 16'(H_TOTAL - 1)) begin
                x_n = 16'd0;
                y_n = (pixel_y == 16'(V_TOTAL - 1)) ? 16'd0 : pixel_y + 16'd1;
            end else begin
                x_n = pixel_x + 16'd1;
                y_n = pixel_y;
            end
            // Sync loads override the free-running count.
            if (h_edge)  x_n = 16'(H_SYNC_START);
            if (v_start) y_n = 16'(V_SYNC_START);

            // Horizontal faults take priority over vertical ones.
            case (state)
                H_ALIGN: begin
                    if (h_bad || w_bad) begin
                        err_n = 1'b1;
                    end else if (v_start) begin
                        state_n    = VERIFY;
                        good_cnt_n = '0;
                    end
                end
                VERIFY: begin
                    if (h_bad || w_bad) begin
                        err_n      = 1'b1;
                        state_n    = H_ALIGN;
                        good_cnt_n = '0;
                    end else if (v_bad) begin
                        err_n      = 1'b1;
                        good_cnt_n = '0;
                    end else if (v_start) begin
                        good_cnt_n = good_cnt + CW'(1);
                        if (good_cnt_n == CW'(LOCK_FRAMES)) state_n = LOCKED;
                    end
                end
                LOCKED: begin
                    if (h_bad || w_bad) begin
                        err_n      = 1'b1;
                        state_n    = H_ALIGN;
                        good_cnt_n = '0;
                    end else if (v_bad) begin
                        err_n      = 1'b1;
                        state_n    = VERIFY;
                        good_cnt_n = '0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Status outputs come from the next-state values so they line up with
    // the coordinates they describe.
    always_ff @(posedge clk_div or posedge reset) begin
        if (reset) begin
            hs_d1        <= 1'b1;
            hs_d2        <= 1'b1;
            hs_d3        <= 1'b1;
            vs_d1        <= 1'b1;
            vs_d2        <= 1'b1;
            line_vs      <= 1'b1;
            state        <= SEARCH;
            good_cnt     <= '0;
            wd           <= 16'd0;
            pixel_x      <= 16'd0;
            pixel_y      <= 16'd0;
            video_active <= 1'b0;
            locked       <= 1'b0;
            frame_start  <= 1'b0;
            sync_error   <= 1'b0;
        end else begin
            hs_d1        <= hsync;
            hs_d2        <= hs_d1;
            hs_d3        <= hs_d2;
            vs_d1        <= vsync;
            vs_d2        <= vs_d1;
            if (h_edge) line_vs <= vs_d2;
            state        <= state_n;
            good_cnt     <= good_cnt_n;
            wd           <= wd_n;
            pixel_x      <= x_n;
            pixel_y      <= y_n;
            sync_error   <= err_n;
            locked       <= (state_n == LOCKED);
            frame_start  <= (state_n == LOCKED) && (x_n == 16'd0) && (y_n == 16'd0);
            video_active <= (state_n == LOCKED) && (x_n < 16'(H_VISIBLE)) &&
                            (y_n < 16'(V_VISIBLE));
        end
    end

endmodule
